// File: rtl/serial_word_receiver_if.sv
// Serial word receiver bus: serial bit side in, word handshake side out.
interface serial_word_receiver_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic                  bit_in;
  logic                  bit_valid;
  logic                  start;
  logic                  abort;
  logic                  word_ready;
  logic                  clear_overrun;
  logic [DATA_WIDTH-1:0] word_out;
  logic                  word_valid;
  logic                  busy;
  logic [CNT_W-1:0]      bit_count;
  logic                  overrun;

  // Producer / consumer side
  modport master (
    output bit_in, bit_valid, start, abort, word_ready, clear_overrun,
    input  word_out, word_valid, busy, bit_count, overrun
  );

  // Receiver side
  modport slave (
    input  bit_in, bit_valid, start, abort, word_ready, clear_overrun,
    output word_out, word_valid, busy, bit_count, overrun
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Deserializes an MSB-first framed bit stream into words held in a
// one-entry valid/ready output buffer with a sticky overrun flag.
module serial_word_receiver #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_word_receiver_if.slave sif
);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic                  handshake;
  logic                  complete;
  logic [DATA_WIDTH-1:0] shifted;

  assign handshake = valid_q && sif.word_ready;
  assign shifted   = {shift_q[DATA_WIDTH-2:0], sif.bit_in};

  // Frame control (abort > start > bit_valid), bit assembly and buffer update
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    if (sif.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (sif.start) begin
      state_d = RECV;
      if (sif.bit_valid) begin
        shift_d = DATA_WIDTH'(sif.bit_in);
        cnt_d   = CNT_W'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (state_q == RECV && sif.bit_valid) begin
      shift_d = shifted;
      if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A completed word needs a free or draining buffer, otherwise it is dropped
    if (complete) begin
      if (!valid_q || handshake) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    if (sif.clear_overrun && !(complete && valid_q && !handshake)) begin
      ovr_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sif.word_out   = word_q;
  assign sif.word_valid = valid_q;
  assign sif.busy       = (state_q == RECV);
  assign sif.bit_count  = cnt_q;
  assign sif.overrun    = ovr_q;

endmodule
